// File: rtl/guess_pkg.sv
// Shared types for the number-guessing controller: FSM states, compare results
// and the LFSR feedback mask.
package guess_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY1,
        ST_ENTRY2,
        ST_ARMED,
        ST_CHECK,
        ST_WIN,
        ST_LOSE
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'b00,
        RES_LOW     = 2'b01,
        RES_HIGH    = 2'b10,
        RES_CORRECT = 2'b11
    } result_t;

    // Right-shifting Galois mask for x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic result_t compareGuess(input logic [7:0] guess, input logic [7:0] secret);
        if (guess < secret)
            return RES_LOW;
        else if (guess > secret)
            return RES_HIGH;
        else
            return RES_CORRECT;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR; a nonzero seed keeps it out of the all-zero lock-up state.
module lfsr8
    import guess_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = {1'b0, q_q[7:1]} ^ (q_q[0] ? LFSR_TAPS : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst)
            q_q <= SEED;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// Number-guessing game: two-digit hex entry from a keypad, compare against a
// secret, and a two-digit multiplexed display of the guess or the secret.
module guess_game_ctrl
    import guess_pkg::*;
#(
    parameter int         CLK_FREQ     = 50_000_000,
    parameter int         REFRESH_DIV  = CLK_FREQ / 1000,
    parameter int         MAX_TRIES    = 8,
    parameter logic [7:0] LFSR_SEED    = 8'hA5,
    parameter logic [7:0] FIXED_SECRET = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       enter,
    output logic [3:0] disp_digit,
    output logic       chip_sel,
    output logic [1:0] result,
    output logic [3:0] tries,
    output logic       game_over
);

    localparam int         REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [3:0] MAX_T4 = 4'(MAX_TRIES);
    localparam logic [4:0] MAX_T5 = 5'(MAX_TRIES);

    state_t           state_q, state_d;
    logic [7:0]       guess_q, guess_d;
    logic [7:0]       secret_q, secret_d;
    logic [3:0]       tries_q, tries_d;
    result_t          result_q, result_d;
    logic [REF_W-1:0] refresh_q, refresh_d;
    logic             chip_q, chip_d;
    logic [7:0]       lfsr_val;
    logic [7:0]       disp_val;

    lfsr8 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk(clk),
        .rst(rst),
        .q  (lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            guess_q   <= 8'h00;
            secret_q  <= 8'h00;
            tries_q   <= 4'd0;
            result_q  <= RES_NONE;
            refresh_q <= '0;
            chip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            guess_q   <= guess_d;
            secret_q  <= secret_d;
            tries_q   <= tries_d;
            result_q  <= result_d;
            refresh_q <= refresh_d;
            chip_q    <= chip_d;
        end
    end

    // In ARMED, enter takes priority over a simultaneous key press.
    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        secret_d = secret_q;
        tries_d  = tries_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (enter) begin
                    secret_d = (FIXED_SECRET != 8'h00) ? FIXED_SECRET : lfsr_val;
                    tries_d  = 4'd0;
                    result_d = RES_NONE;
                    state_d  = ST_ENTRY1;
                end
            end
            ST_ENTRY1: begin
                if (key_valid) begin
                    guess_d = {key_code, 4'h0};
                    state_d = ST_ENTRY2;
                end
            end
            ST_ENTRY2: begin
                if (key_valid) begin
                    guess_d = {guess_q[7:4], key_code};
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (enter) begin
                    state_d = ST_CHECK;
                end else if (key_valid) begin
                    guess_d = {key_code, 4'h0};
                    state_d = ST_ENTRY2;
                end
            end
            ST_CHECK: begin
                result_d = compareGuess(guess_q, secret_q);
                tries_d  = (tries_q < MAX_T4) ? tries_q + 4'd1 : tries_q;
                if (guess_q == secret_q)
                    state_d = ST_WIN;
                else if (({1'b0, tries_q} + 5'd1) == MAX_T5)
                    state_d = ST_LOSE;
                else
                    state_d = ST_ENTRY1;
            end
            ST_WIN, ST_LOSE: begin
                if (enter)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        refresh_d = refresh_q + REF_W'(1);
        chip_d    = chip_q;
        if (refresh_q == REF_LAST) begin
            refresh_d = '0;
            chip_d    = ~chip_q;
        end
    end

    always_comb begin
        disp_val = 8'h00;
        case (state_q)
            ST_ENTRY1, ST_ENTRY2, ST_ARMED, ST_CHECK: disp_val = guess_q;
            ST_WIN, ST_LOSE:                         disp_val = secret_q;
            default:                                 disp_val = 8'h00;
        endcase
    end

    assign disp_digit = chip_q ? disp_val[7:4] : disp_val[3:0];
    assign chip_sel   = chip_q;
    assign result     = result_q;
    assign tries      = tries_q;
    assign game_over  = (state_q == ST_WIN) || (state_q == ST_LOSE);

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Three controller instances (different secrets / try limits) driven in lockstep
// and compared every cycle against a game-rules reference model.
module tb_guess_game_ctrl;
    import guess_pkg::*;

    localparam int RDIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       keyValid;
    logic [3:0] keyCode;
    logic       enter;

    logic [3:0] dispDigit [3];
    logic       chipSel   [3];
    logic [1:0] resultOut [3];
    logic [3:0] triesOut  [3];
    logic       gameOver  [3];
    state_t     dutState  [3];
    logic [7:0] lfsrC;

    int         maxTries    [3] = '{8, 2, 3};
    logic [7:0] fixedSecret [3] = '{8'h3C, 8'h10, 8'h00};
    logic [7:0] seeds       [3] = '{8'hA5, 8'hA5, 8'h5A};

    state_t     mState  [3];
    logic [7:0] mGuess  [3];
    logic [7:0] mSecret [3];
    int         mTries  [3];
    int         mResult [3];
    logic [7:0] mLfsr   [3];
    int         mCyc    [3];

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    guess_game_ctrl #(.REFRESH_DIV(RDIV), .MAX_TRIES(8), .LFSR_SEED(8'hA5), .FIXED_SECRET(8'h3C)) dutA (
        .clk(clk), .rst(rst), .key_valid(keyValid), .key_code(keyCode), .enter(enter),
        .disp_digit(dispDigit[0]), .chip_sel(chipSel[0]), .result(resultOut[0]),
        .tries(triesOut[0]), .game_over(gameOver[0]));

    guess_game_ctrl #(.REFRESH_DIV(RDIV), .MAX_TRIES(2), .LFSR_SEED(8'hA5), .FIXED_SECRET(8'h10)) dutB (
        .clk(clk), .rst(rst), .key_valid(keyValid), .key_code(keyCode), .enter(enter),
        .disp_digit(dispDigit[1]), .chip_sel(chipSel[1]), .result(resultOut[1]),
        .tries(triesOut[1]), .game_over(gameOver[1]));

    guess_game_ctrl #(.REFRESH_DIV(RDIV), .MAX_TRIES(3), .LFSR_SEED(8'h5A), .FIXED_SECRET(8'h00)) dutC (
        .clk(clk), .rst(rst), .key_valid(keyValid), .key_code(keyCode), .enter(enter),
        .disp_digit(dispDigit[2]), .chip_sel(chipSel[2]), .result(resultOut[2]),
        .tries(triesOut[2]), .game_over(gameOver[2]));

    assign dutState[0] = dutA.state_q;
    assign dutState[1] = dutB.state_q;
    assign dutState[2] = dutC.state_q;
    assign lfsrC       = dutC.u_lfsr.q;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    endtask

    function automatic logic [7:0] lfsrStep(input logic [7:0] v);
        logic [7:0] shifted;
        shifted = v >> 1;
        return v[0] ? (shifted ^ 8'hB8) : shifted;
    endfunction

    // Game rules applied to each instance for one clock edge.
    task automatic modelUpdate(input bit r, input bit kv, input logic [3:0] kc, input bit en);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                mState[i] = ST_IDLE;  mGuess[i] = 8'h00; mSecret[i] = 8'h00;
                mTries[i] = 0;        mResult[i] = 0;    mLfsr[i] = seeds[i];
                mCyc[i]   = 0;
            end else begin
                case (mState[i])
                    ST_IDLE: if (en) begin
                        mSecret[i] = (fixedSecret[i] != 0) ? fixedSecret[i] : mLfsr[i];
                        mTries[i]  = 0;
                        mResult[i] = 0;
                        mState[i]  = ST_ENTRY1;
                    end
                    ST_ENTRY1: if (kv) begin
                        mGuess[i] = {kc, 4'h0};
                        mState[i] = ST_ENTRY2;
                    end
                    ST_ENTRY2: if (kv) begin
                        mGuess[i] = {mGuess[i][7:4], kc};
                        mState[i] = ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (en) mState[i] = ST_CHECK;
                        else if (kv) begin
                            mGuess[i] = {kc, 4'h0};
                            mState[i] = ST_ENTRY2;
                        end
                    end
                    ST_CHECK: begin
                        int g, s;
                        g = int'(mGuess[i]);
                        s = int'(mSecret[i]);
                        mResult[i] = (g < s) ? 1 : (g > s) ? 2 : 3;
                        if (g == s) mState[i] = ST_WIN;
                        else if (mTries[i] + 1 == maxTries[i]) mState[i] = ST_LOSE;
                        else mState[i] = ST_ENTRY1;
                        if (mTries[i] < maxTries[i]) mTries[i]++;
                    end
                    default: if (en) mState[i] = ST_IDLE;
                endcase
                mLfsr[i] = lfsrStep(mLfsr[i]);
                mCyc[i]++;
            end
        end
    endtask

    task automatic compareAll();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] shown;
            bit         chip;
            bit         over;
            chip  = ((mCyc[i] / RDIV) % 2) == 1;
            over  = (mState[i] == ST_WIN) || (mState[i] == ST_LOSE);
            shown = (mState[i] == ST_IDLE) ? 8'h00 : over ? mSecret[i] : mGuess[i];
            checkOutput($sformatf("state[%0d]", i),    32'(dutState[i]),  32'(mState[i]));
            checkOutput($sformatf("result[%0d]", i),   32'(resultOut[i]), 32'(mResult[i]));
            checkOutput($sformatf("tries[%0d]", i),    32'(triesOut[i]),  32'(mTries[i]));
            checkOutput($sformatf("gameOver[%0d]", i), 32'(gameOver[i]),  32'(over));
            checkOutput($sformatf("chipSel[%0d]", i),  32'(chipSel[i]),   32'(chip));
            checkOutput($sformatf("digit[%0d]", i),    32'(dispDigit[i]), 32'(chip ? shown[7:4] : shown[3:0]));
        end
        checkOutput("lfsrC", 32'(lfsrC), 32'(mLfsr[2]));
        checkOutput("lfsrNonZero", 32'(lfsrC != 8'h00), 32'd1);
    endtask

    task automatic applyStimulus(input bit r, input bit kv, input logic [3:0] kc, input bit en);
        rst      = r;
        keyValid = kv;
        keyCode  = kc;
        enter    = en;
        @(posedge clk);
        modelUpdate(r, kv, kc, en);
        #1;
        compareAll();
    endtask

    initial begin
        rst = 1'b1; keyValid = 1'b0; keyCode = 4'h0; enter = 1'b0;

        applyStimulus(1, 0, 4'h0, 0);
        checkOutput("resetTries", 32'(triesOut[0]), 32'd0);
        checkOutput("resetState", 32'(dutState[0]), 32'(ST_IDLE));

        // First game: 2A low, 41 high, 3C correct
        applyStimulus(0, 0, 4'h0, 1);
        applyStimulus(0, 1, 4'h2, 0);
        applyStimulus(0, 1, 4'hA, 0);
        applyStimulus(0, 0, 4'h0, 1);
        applyStimulus(0, 0, 4'h0, 0);
        checkOutput("lowResult", 32'(resultOut[0]), 32'd1);
        checkOutput("lowTries", 32'(triesOut[0]), 32'd1);
        checkOutput("lowState", 32'(dutState[0]), 32'(ST_ENTRY1));

        applyStimulus(0, 1, 4'h4, 0);
        applyStimulus(0, 1, 4'h1, 0);
        applyStimulus(0, 0, 4'h0, 1);
        applyStimulus(0, 0, 4'h0, 0);
        checkOutput("highResult", 32'(resultOut[0]), 32'd2);
        checkOutput("highTries", 32'(triesOut[0]), 32'd2);
        checkOutput("loseState", 32'(dutState[1]), 32'(ST_LOSE));
        checkOutput("loseTries", 32'(triesOut[1]), 32'd2);
        checkOutput("loseOver", 32'(gameOver[1]), 32'd1);

        applyStimulus(0, 1, 4'h3, 0);
        applyStimulus(0, 1, 4'hC, 0);
        applyStimulus(0, 0, 4'h0, 1);
        checkOutput("loseToIdle", 32'(dutState[1]), 32'(ST_IDLE));
        applyStimulus(0, 0, 4'h0, 0);
        checkOutput("winResult", 32'(resultOut[0]), 32'd3);
        checkOutput("winOver", 32'(gameOver[0]), 32'd1);
        for (int n = 0; n < 8; n++) begin
            applyStimulus(0, 0, 4'h0, 0);
            checkOutput("winDisplay", 32'(dispDigit[0]), (((mCyc[0] / RDIV) % 2) == 1) ? 32'h3 : 32'hC);
        end

        // New game; key and enter together in ARMED must check the old guess 55
        applyStimulus(0, 0, 4'h0, 1);
        applyStimulus(0, 0, 4'h0, 1);
        applyStimulus(0, 1, 4'h5, 0);
        applyStimulus(0, 1, 4'h5, 0);
        applyStimulus(0, 1, 4'h7, 1);
        checkOutput("collideState", 32'(dutState[0]), 32'(ST_CHECK));
        applyStimulus(0, 0, 4'h0, 0);
        checkOutput("collideResult", 32'(resultOut[0]), 32'd2);
        checkOutput("collideTries", 32'(triesOut[0]), 32'd1);
        checkOutput("collideDigit", 32'(dispDigit[0]), 32'h5);

        // Reset in the middle of entry
        applyStimulus(0, 1, 4'h1, 0);
        applyStimulus(1, 1, 4'h9, 1);
        checkOutput("midResetState", 32'(dutState[0]), 32'(ST_IDLE));
        checkOutput("midResetResult", 32'(resultOut[0]), 32'd0);
        checkOutput("midResetDigit", 32'(dispDigit[0]), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 2) == 0,
                          4'($urandom_range(0, 15)),
                          $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
